// File: rtl/cpu_pkg.sv
// Shared widths, branch-select encodings and fetch FSM states for the CPU front end.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 17;

  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JR   = 2'b10;
  localparam logic [1:0] BS_REL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational branch resolution: decides whether execute redirects the PC and where to.
module pc_next_logic
  import cpu_pkg::*;
(
  input  logic              br_valid_i,
  input  logic [1:0]        bs_i,
  input  logic              ps_i,
  input  logic              zero_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  input  logic [ADDR_W-1:0] jr_addr_i,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] target_o
);

  logic [ADDR_W-1:0] rel_target_s;

  assign rel_target_s = br_pc_i + br_offset_i;

  // PS flips the sense of the Z test: PS=0 branches on zero, PS=1 on non-zero.
  always_comb begin
    redirect_o = 1'b0;
    target_o   = rel_target_s;
    case (bs_i)
      BS_NONE: begin
        redirect_o = 1'b0;
        target_o   = rel_target_s;
      end
      BS_COND: begin
        redirect_o = br_valid_i & (zero_i ^ ps_i);
        target_o   = rel_target_s;
      end
      BS_JR: begin
        redirect_o = br_valid_i;
        target_o   = jr_addr_i;
      end
      BS_REL: begin
        redirect_o = br_valid_i;
        target_o   = rel_target_s;
      end
      default: begin
        redirect_o = 1'b0;
        target_o   = rel_target_s;
      end
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: sequential PC, single-entry instruction register and
// branch redirect handling, including discard of a fetch already in flight.
module inst_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               decode_ready,
  input  logic               br_valid,
  input  logic [1:0]         BS,
  input  logic               PS,
  input  logic               zero,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [ADDR_W-1:0]  br_offset,
  input  logic [ADDR_W-1:0]  jr_addr
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               discard_q, discard_d;
  logic [ADDR_W-1:0]  tgt_q, tgt_d;
  logic               redirect_s;
  logic [ADDR_W-1:0]  target_s;

  pc_next_logic u_pc_next_logic (
    .br_valid_i  (br_valid),
    .bs_i        (BS),
    .ps_i        (PS),
    .zero_i      (zero),
    .br_pc_i     (br_pc),
    .br_offset_i (br_offset),
    .jr_addr_i   (jr_addr),
    .redirect_o  (redirect_s),
    .target_o    (target_s)
  );

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    valid_d   = valid_q;
    discard_d = discard_q;
    tgt_d     = tgt_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_s) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (discard_q || redirect_s) begin
            // Stale or superseded fetch: drop the data and refetch from the target.
            pc_d      = redirect_s ? target_s : tgt_q;
            discard_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + 16'd1;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect_s) begin
          discard_d = 1'b1;
          tgt_d     = target_s;
        end else begin
          discard_d = discard_q;
        end
      end
      HOLD: begin
        if (redirect_s) begin
          pc_d    = target_s;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (valid_q && decode_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= 16'd0;
      instr_q   <= 17'd0;
      ipc_q     <= 16'd0;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
      tgt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
      tgt_q     <= tgt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, stall, branch flush, in-flight discard, wrap, reset.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [16:0] imem_rdata;
  logic [16:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready;
  logic        br_valid;
  logic [1:0]  BS;
  logic        PS;
  logic        zero;
  logic [15:0] br_pc;
  logic [15:0] br_offset;
  logic [15:0] jr_addr;

  int total_cnt;
  int bad_cnt;

  inst_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .br_valid     (br_valid),
    .BS           (BS),
    .PS           (PS),
    .zero         (zero),
    .br_pc        (br_pc),
    .br_offset    (br_offset),
    .jr_addr      (jr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mem_word(input logic [15:0] a);
    mem_word = {a[0] ^ a[15], a ^ 16'h5A3C};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt = 0;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    decode_ready = 1'b0;
    br_valid = 1'b0;
    BS = 2'b00;
    PS = 1'b0;
    zero = 1'b0;
    br_pc = 16'd0;
    br_offset = 16'd0;
    jr_addr = 16'd0;
    #1;
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'd0);
    chk("rst_iout", {15'd0, instr_out}, 32'd0);
    chk("rst_ipc", {16'd0, instr_pc}, 32'd0);

    // Release reset with ack tied high: IDLE first, then fetches 0,1,2.
    rst_n = 1'b1;
    decode_ready = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {16'd0, imem_addr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_valid", {31'd0, instr_valid}, 32'd1);
      chk("seq_ipc", {16'd0, instr_pc}, i);
      chk("seq_iout", {15'd0, instr_out}, {15'd0, mem_word(i[15:0])});
      chk("seq_hold_req", {31'd0, imem_req}, 32'd0);
      if (i < 2) begin
        tick();
        chk("seq_valid_clr", {31'd0, instr_valid}, 32'd0);
        chk("seq_addr", {16'd0, imem_addr}, i + 1);
      end
    end

    // Decoder stall for 5 cycles.
    decode_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_iout", {15'd0, instr_out}, {15'd0, mem_word(16'd2)});
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    decode_ready = 1'b1;
    tick();
    chk("resume_addr", {16'd0, imem_addr}, 32'd3);
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("pc3_ipc", {16'd0, instr_pc}, 32'd3);

    // Taken conditional in HOLD: 10 + (-4) = 6, wins over decode_ready.
    br_valid = 1'b1;
    BS = 2'b01;
    PS = 1'b0;
    zero = 1'b1;
    br_pc = 16'd10;
    br_offset = 16'hFFFC;
    tick();
    br_valid = 1'b0;
    chk("br_flush_valid", {31'd0, instr_valid}, 32'd0);
    chk("br_addr", {16'd0, imem_addr}, 32'd6);
    tick();
    chk("br_ipc", {16'd0, instr_pc}, 32'd6);

    // Untaken conditional: ordinary transfer, sequential address.
    br_valid = 1'b1;
    zero = 1'b0;
    tick();
    br_valid = 1'b0;
    chk("untaken_addr", {16'd0, imem_addr}, 32'd7);
    chk("untaken_req", {31'd0, imem_req}, 32'd1);

    // Jump-register during FETCH, ack delayed: data dropped.
    imem_ack = 1'b0;
    br_valid = 1'b1;
    BS = 2'b10;
    jr_addr = 16'h0100;
    tick();
    br_valid = 1'b0;
    chk("jr_wait_addr", {16'd0, imem_addr}, 32'd7);
    tick();
    chk("jr_wait_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("jr_wait_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    tick();
    chk("jr_drop_valid", {31'd0, instr_valid}, 32'd0);
    chk("jr_drop_req", {31'd0, imem_req}, 32'd1);
    chk("jr_addr", {16'd0, imem_addr}, 32'h0100);
    tick();
    chk("jr_ipc", {16'd0, instr_pc}, 32'h0100);
    chk("jr_iout", {15'd0, instr_out}, {15'd0, mem_word(16'h0100)});

    // PC wrap at 0xFFFF.
    br_valid = 1'b1;
    BS = 2'b10;
    jr_addr = 16'hFFFF;
    tick();
    br_valid = 1'b0;
    chk("wrap_addr", {16'd0, imem_addr}, 32'hFFFF);
    tick();
    chk("wrap_ipc", {16'd0, instr_pc}, 32'hFFFF);
    tick();
    chk("wrap_next", {16'd0, imem_addr}, 32'h0000);
    tick();
    tick();
    chk("pre_rst_addr", {16'd0, imem_addr}, 32'd1);

    // Reset pulse mid-FETCH with ack high.
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_addr", {16'd0, imem_addr}, 32'd0);
    tick();
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_addr", {16'd0, imem_addr}, 32'd0);
    tick();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr2", {16'd0, imem_addr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
